// File: rtl/parity_acc.sv
// parity_acc: XOR-accumulates the beats of each input packet and presents the
// folded word, its parity, the beat count and an overflow flag as one result.
// Only one side of the block is open at a time. Beats are accepted in ACC, and
// the result is held in HOLD until the consumer takes it.
module parity_acc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_word,
    output logic             m_parity,
    output logic [CNT_W-1:0] m_beats,
    output logic             m_ovf
);

    localparam logic             ODD_BIT = 1'(ODD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic               accept;

    // A beat is taken only while the registered ready is high (i.e. in ACC).
    assign accept = s_valid && s_ready_q;

    // Next state and datapath. The count saturates instead of wrapping, so a
    // zero count reliably marks the first beat of a packet.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;

        unique case (state_q)
            // Reset is released between edges, so the first edge after release
            // is a clean edge on which IDLE steps to ACC.
            IDLE: state_d = ACC;
            ACC: begin
                if (accept) begin
                    acc_d = (cnt_q == '0) ? s_data : (acc_q ^ s_data);
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (s_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == ACC);
        m_valid_d = (state_d == HOLD);
    end

    // State, datapath and handshake registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_word   = acc_q;
    assign m_beats  = cnt_q;
    assign m_ovf    = ovf_q;
    // Parity is taken straight from the result register.
    assign m_parity = (^acc_q) ^ ODD_BIT;

endmodule
